// File: rtl/avalon_ram_pkg.sv
// Shared definitions for the Avalon-MM wait-state RAM model.
//   - state_e    : transaction FSM states
//   - LFSR_TAPS  : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   - BYTE_LANES : byte lanes per 32-bit word
//   - byte_merge : per-lane merge of a write into an existing word
package avalon_ram_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int          BYTE_LANES = 4;

  // Replace each enabled byte lane of old_word with the matching lane of new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0]           old_word,
                                             input logic [31:0]           new_word,
                                             input logic [BYTE_LANES-1:0] be);
    logic [31:0] res;
    res = old_word;
    for (int n = 0; n < BYTE_LANES; n++) begin
      res[8*n +: 8] = be[n] ? new_word[8*n +: 8] : old_word[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_wait_ram_lfsr.sv
// wait_lfsr: free-running 16-bit Fibonacci LFSR plus the per-transaction
// wait draw (lfsr % (WAIT_CYCLES+1)).
// Ports:
//   clk_i   : clock
//   reset_i : synchronous active-high reset, loads LFSR_SEED
//   wait_o  : wait length to use if a request is accepted this cycle
module wait_lfsr
  import avalon_ram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [15:0] wait_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift left, feeding back the XOR of the tapped bits.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // LFSR register: advances on every non-reset cycle, independent of bus activity.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign wait_o = lfsr_q % 16'(WAIT_CYCLES + 32'd1);

endmodule

// File: rtl/avalon_wait_ram.sv
// avalon_wait_ram: word-addressed RAM acting as an Avalon-MM slave with
// fixed or pseudo-random wait states, byte-lane writes, sticky error flags
// and a backdoor preload port.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   address/read/write         : Avalon request (byte address)
//   writedata/byteenable       : write data and lane enables
//   waitrequest/readdata       : stall and read data (data only in completion cycle)
//   preload_en/addr/data       : backdoor full-word write, has priority over the bus
//   range_error/protocol_error : sticky error flags, cleared by reset
module avalon_wait_ram
  import avalon_ram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES    = 2,
  parameter int unsigned RANDOM_WAIT    = 0,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned CLEAR_ON_RESET = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    address,
  input  logic                           read,
  input  logic                           write,
  input  logic [31:0]                    writedata,
  input  logic [3:0]                     byteenable,
  output logic                           waitrequest,
  output logic [31:0]                    readdata,
  input  logic                           preload_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] preload_addr,
  input  logic [31:0]                    preload_data,
  output logic                           range_error,
  output logic                           protocol_error
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  // Counter only ever holds W-1, so WAIT_CYCLES-1 is its largest value.
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [31:0]      mem_q [DEPTH_WORDS];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      cap_addr_q, cap_addr_d;
  logic             cap_read_q, cap_read_d;
  logic             cap_write_q, cap_write_d;
  logic             range_error_q;
  logic             protocol_error_q;

  logic [15:0]      w_s;
  logic [31:0]      word_off_s;
  logic             in_range_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      mem_rd_s;
  logic             req_s;
  logic             changed_s;
  logic             complete_s;
  logic             perr_set_s;
  logic             rerr_set_s;
  logic             wr_commit_s;

  // Wait-length source: LFSR draw in random mode, otherwise the constant.
  if (RANDOM_WAIT != 0) begin : g_rand
    wait_lfsr #(
      .WAIT_CYCLES(WAIT_CYCLES),
      .LFSR_SEED  (LFSR_SEED)
    ) u_wait_lfsr (
      .clk_i  (clk),
      .reset_i(reset),
      .wait_o (w_s)
    );
  end else begin : g_fixed
    assign w_s = 16'(WAIT_CYCLES);
  end

  // Address decode. An address below BASE_ADDR wraps to a huge offset, but
  // the explicit >= test is kept so the intent is obvious.
  assign word_off_s = (address - BASE_ADDR) >> 2'd2;
  assign in_range_s = (address >= BASE_ADDR) && (word_off_s < DEPTH_WORDS) &&
                      (address[1:0] == 2'b00);
  assign idx_s      = word_off_s[IDX_W-1:0];
  assign mem_rd_s   = mem_q[idx_s];

  assign req_s      = read ^ write;
  // Anything other than the exact request captured at acceptance is a violation.
  assign changed_s  = (read != cap_read_q) || (write != cap_write_q) ||
                      (address != cap_addr_q);

  // Handshake FSM next-state and waitrequest.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_addr_d  = cap_addr_q;
    cap_read_d  = cap_read_q;
    cap_write_d = cap_write_q;
    waitrequest = 1'b1;
    complete_s  = 1'b0;
    perr_set_s  = 1'b0;
    if (reset || preload_en) begin
      // Reset and backdoor preload both stall the bus with all state frozen.
      waitrequest = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (read && write) begin
            waitrequest = 1'b0;
            perr_set_s  = 1'b1;
          end else if (req_s) begin
            if (w_s == 16'd0) begin
              waitrequest = 1'b0;
              complete_s  = 1'b1;
            end else begin
              waitrequest = 1'b1;
              cnt_d       = CNT_W'(w_s - 16'd1);
              state_d     = BUSY;
              cap_addr_d  = address;
              cap_read_d  = read;
              cap_write_d = write;
            end
          end else begin
            waitrequest = 1'b0;
          end
        end
        BUSY: begin
          if (changed_s) begin
            // Keep stalling in the abort cycle so a changed request is never
            // mistaken for a completion; it is re-accepted fresh from IDLE.
            waitrequest = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
            perr_set_s  = 1'b1;
          end else if (cnt_q != '0) begin
            waitrequest = 1'b1;
            cnt_d       = cnt_q - CNT_W'(1'b1);
          end else begin
            waitrequest = 1'b0;
            complete_s  = 1'b1;
            state_d     = IDLE;
          end
        end
        default: begin
          waitrequest = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
        end
      endcase
    end
  end

  // Completion-cycle effects: read data, write commit, range error.
  always_comb begin
    readdata    = 32'h0;
    wr_commit_s = 1'b0;
    rerr_set_s  = 1'b0;
    if (complete_s) begin
      if (in_range_s) begin
        if (read) begin
          readdata = mem_rd_s;
        end else begin
          wr_commit_s = 1'b1;
        end
      end else begin
        rerr_set_s = 1'b1;
      end
    end else begin
      readdata = 32'h0;
    end
  end

  // FSM state, captured request and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      cap_addr_q       <= 32'h0;
      cap_read_q       <= 1'b0;
      cap_write_q      <= 1'b0;
      range_error_q    <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      cap_addr_q       <= cap_addr_d;
      cap_read_q       <= cap_read_d;
      cap_write_q      <= cap_write_d;
      range_error_q    <= range_error_q | rerr_set_s;
      protocol_error_q <= protocol_error_q | perr_set_s;
    end
  end

  // Storage. The preload assignment comes last so it wins on a shared index.
  always_ff @(posedge clk) begin
    if (reset && (CLEAR_ON_RESET != 0)) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      if (wr_commit_s) begin
        mem_q[idx_s] <= byte_merge(mem_rd_s, writedata, byteenable);
      end
      if (preload_en) begin
        mem_q[preload_addr] <= preload_data;
      end
    end
  end

  assign range_error    = range_error_q;
  assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Three RAM instances: 0 = fixed 2-cycle wait at base 0, 1 = zero wait with
// clear-on-reset, 2 = random wait (0..3) at base 0xBFC00000.
module tb_avalon_wait_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr [3];
  logic        rd [3];
  logic        wr [3];
  logic [31:0] wdata [3];
  logic [3:0]  be [3];
  logic        wreq [3];
  logic [31:0] rdata [3];
  logic        pl_en [3];
  logic [7:0]  pl_addr [3];
  logic [31:0] pl_data [3];
  logic        rerr [3];
  logic        perr [3];

  logic [31:0] mmem [3][256];
  logic        m_rerr [3];
  logic        m_perr [3];
  logic [15:0] m_lfsr;
  int          hist [4];
  logic [31:0] rd_last;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, advancing every non-reset cycle.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  avalon_wait_ram #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(2),
                    .RANDOM_WAIT(0), .LFSR_SEED(16'hACE1), .CLEAR_ON_RESET(0)) dut0 (
    .clk(clk), .reset(reset), .address(addr[0]), .read(rd[0]), .write(wr[0]),
    .writedata(wdata[0]), .byteenable(be[0]), .waitrequest(wreq[0]), .readdata(rdata[0]),
    .preload_en(pl_en[0]), .preload_addr(pl_addr[0]), .preload_data(pl_data[0]),
    .range_error(rerr[0]), .protocol_error(perr[0]));

  avalon_wait_ram #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0),
                    .RANDOM_WAIT(0), .LFSR_SEED(16'hACE1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset(reset), .address(addr[1]), .read(rd[1]), .write(wr[1]),
    .writedata(wdata[1]), .byteenable(be[1]), .waitrequest(wreq[1]), .readdata(rdata[1]),
    .preload_en(pl_en[1]), .preload_addr(pl_addr[1]), .preload_data(pl_data[1]),
    .range_error(rerr[1]), .protocol_error(perr[1]));

  avalon_wait_ram #(.DEPTH_WORDS(256), .BASE_ADDR(32'hBFC0_0000), .WAIT_CYCLES(3),
                    .RANDOM_WAIT(1), .LFSR_SEED(16'hACE1), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .reset(reset), .address(addr[2]), .read(rd[2]), .write(wr[2]),
    .writedata(wdata[2]), .byteenable(be[2]), .waitrequest(wreq[2]), .readdata(rdata[2]),
    .preload_en(pl_en[2]), .preload_addr(pl_addr[2]), .preload_data(pl_data[2]),
    .range_error(rerr[2]), .protocol_error(perr[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? 32'hBFC0_0000 : 32'h0;
  endfunction

  function automatic bit in_rng(input int k, input logic [31:0] a);
    logic [31:0] off;
    off = a - base_of(k);
    return (a >= base_of(k)) && (off < 32'd1024) && (a[1:0] == 2'b00);
  endfunction

  function automatic int exp_wait(input int k);
    if (k == 2) return int'(m_lfsr % 16'd4);
    else if (k == 0) return 2;
    else return 0;
  endfunction

  // One bus transfer on instance k; optionally holds preload of the same
  // word for pre_n cycles first. Called and returns at posedge+1.
  task automatic bus_txn(input int k, input bit is_wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         input int pre_n, input logic [31:0] pl_val);
    int cyc;
    int ew;
    bit done;
    bit ok;
    logic [7:0] ix;
    logic [31:0] off;
    logic [31:0] got;
    ok  = in_rng(k, a);
    off = a - base_of(k);
    ix  = off[9:2];
    addr[k] = a; rd[k] = !is_wr; wr[k] = is_wr; wdata[k] = d; be[k] = b;
    for (int i = 0; i < pre_n; i++) begin
      pl_en[k] = 1'b1; pl_addr[k] = ix; pl_data[k] = pl_val;
      @(negedge clk);
      check_val("preload_stall", {31'b0, wreq[k]}, 32'd1);
      check_val("preload_rdata", rdata[k], 32'h0);
      @(posedge clk); #1;
      mmem[k][ix] = pl_val;
    end
    pl_en[k] = 1'b0;
    ew = exp_wait(k); cyc = 0; done = 1'b0; got = 32'h0;
    while (!done && cyc <= 12) begin
      @(negedge clk);
      if (wreq[k] == 1'b0) begin
        done = 1'b1;
        got = rdata[k];
      end else begin
        check_val("busy_rdata", rdata[k], 32'h0);
        cyc++;
        @(posedge clk); #1;
      end
    end
    check_val("handshake_done", {31'b0, done}, 32'd1);
    check_val("wait_len", 32'(cyc), 32'(ew));
    if (k == 2 && done && cyc < 4) hist[cyc]++;
    if (!is_wr) check_val("read_data", got, ok ? mmem[k][ix] : 32'h0);
    else if (ok) begin
      for (int n = 0; n < 4; n++) if (b[n]) mmem[k][ix][8*n +: 8] = d[8*n +: 8];
    end
    if (!ok) m_rerr[k] = 1'b1;
    rd_last = got;
    @(posedge clk); #1;
    check_val("range_flag", {31'b0, rerr[k]}, {31'b0, m_rerr[k]});
    check_val("proto_flag", {31'b0, perr[k]}, {31'b0, m_perr[k]});
  endtask

  task automatic bus_idle(input int k);
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  task automatic preload_word(input int k, input logic [7:0] ix, input logic [31:0] v);
    pl_en[k] = 1'b1; pl_addr[k] = ix; pl_data[k] = v;
    @(posedge clk); #1;
    pl_en[k] = 1'b0;
    mmem[k][ix] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check_val("reset_wait", {31'b0, wreq[k]}, 32'd1);
        check_val("reset_rdata", rdata[k], 32'h0);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      bus_idle(k);
      m_rerr[k] = 1'b0; m_perr[k] = 1'b0;
    end
    for (int i = 0; i < 256; i++) mmem[1][i] = 32'h0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val("reset_rerr", {31'b0, rerr[k]}, 32'd0);
      check_val("reset_perr", {31'b0, perr[k]}, 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] base;
    int ix;
    for (int k = 0; k < 3; k++) begin
      addr[k] = 32'h0; rd[k] = 1'b0; wr[k] = 1'b0; wdata[k] = 32'h0; be[k] = 4'h0;
      pl_en[k] = 1'b0; pl_addr[k] = 8'h0; pl_data[k] = 32'h0;
    end
    for (int i = 0; i < 4; i++) hist[i] = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Fill every word of every instance through the backdoor.
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 3; k++) begin
        pl_en[k] = 1'b1; pl_addr[k] = 8'(i); pl_data[k] = $urandom;
        mmem[k][i] = pl_data[k];
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) pl_en[k] = 1'b0;

    // Fixed wait read and byte-lane write.
    preload_word(0, 8'd1, 32'h2402_0010);
    bus_txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'h0);
    check_val("tp_fixed_read", rd_last, 32'h2402_0010);
    bus_idle(0);
    preload_word(0, 8'd2, 32'h1122_3344);
    bus_txn(0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, 0, 32'h0);
    bus_txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h0);
    check_val("tp_byte_lanes", rd_last, 32'h11BB_33DD);
    bus_txn(0, 1'b1, 32'h8, 32'h0, 4'b0000, 0, 32'h0);
    bus_txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h0);
    check_val("tp_be_zero", rd_last, 32'h11BB_33DD);
    bus_idle(0);

    // Zero wait, back-to-back.
    bus_txn(1, 1'b1, 32'hC, 32'hCAFE_0001, 4'hF, 0, 32'h0);
    bus_txn(1, 1'b1, 32'h10, 32'hCAFE_0002, 4'hF, 0, 32'h0);
    bus_txn(1, 1'b0, 32'hC, 32'h0, 4'h0, 0, 32'h0);
    check_val("tp_zw_read0", rd_last, 32'hCAFE_0001);
    bus_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'h0);
    check_val("tp_zw_read1", rd_last, 32'hCAFE_0002);
    bus_idle(1);

    // Range errors on the relocated instance.
    bus_txn(2, 1'b0, 32'hBFC0_0400, 32'h0, 4'h0, 0, 32'h0);
    bus_txn(2, 1'b0, 32'hBFC0_0002, 32'h0, 4'h0, 0, 32'h0);
    bus_txn(2, 1'b0, 32'hBFBF_FFFC, 32'h0, 4'h0, 0, 32'h0);
    bus_txn(2, 1'b1, 32'hBFC0_03FD, 32'h1234_5678, 4'hF, 0, 32'h0);
    bus_txn(2, 1'b0, 32'hBFC0_03FC, 32'h0, 4'h0, 0, 32'h0);
    bus_idle(2);

    // read and write together: no access, immediate ack.
    addr[0] = 32'h8; rd[0] = 1'b1; wr[0] = 1'b1; wdata[0] = 32'hFFFF_FFFF; be[0] = 4'hF;
    @(negedge clk);
    check_val("both_wait", {31'b0, wreq[0]}, 32'd0);
    check_val("both_rdata", rdata[0], 32'h0);
    @(posedge clk); #1;
    bus_idle(0); m_perr[0] = 1'b1;
    check_val("both_flag", {31'b0, perr[0]}, 32'd1);
    bus_txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h0);
    bus_idle(0);

    // Dropped request mid-wait.
    do_reset();
    addr[0] = 32'h4; rd[0] = 1'b1;
    @(negedge clk);
    check_val("drop_wait", {31'b0, wreq[0]}, 32'd1);
    @(posedge clk); #1;
    rd[0] = 1'b0;
    @(negedge clk);
    check_val("drop_rdata", rdata[0], 32'h0);
    @(posedge clk); #1;
    m_perr[0] = 1'b1;
    check_val("drop_flag", {31'b0, perr[0]}, 32'd1);
    bus_txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'h0);
    bus_idle(0);

    // Reset in the middle of a write: nothing committed.
    addr[0] = 32'h4; wr[0] = 1'b1; wdata[0] = 32'hDEAD_BEEF; be[0] = 4'hF;
    @(negedge clk);
    check_val("midrst_wait", {31'b0, wreq[0]}, 32'd1);
    @(posedge clk); #1;
    do_reset();
    bus_txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'h0);
    bus_idle(0);
    bus_txn(1, 1'b0, 32'hC, 32'h0, 4'h0, 0, 32'h0);
    check_val("clear_on_reset", rd_last, 32'h0);
    bus_idle(1);

    // Preload held during a pending request.
    bus_txn(2, 1'b0, 32'hBFC0_0044, 32'h0, 4'h0, 5, 32'h5A5A_0F0F);
    check_val("preload_wins", rd_last, 32'h5A5A_0F0F);
    bus_txn(2, 1'b1, 32'hBFC0_0048, 32'h0000_00EE, 4'b0001, 5, 32'h7777_7777);
    bus_txn(2, 1'b0, 32'hBFC0_0048, 32'h0, 4'h0, 0, 32'h0);
    bus_idle(2);

    // 200 random-wait reads.
    for (int n = 0; n < 200; n++) begin
      ix = $urandom_range(0, 255);
      bus_txn(2, 1'b0, 32'hBFC0_0000 + 32'(ix) * 32'd4, 32'h0, 4'h0, 0, 32'h0);
      if ($urandom_range(0, 1) == 1) begin
        bus_idle(2);
        @(posedge clk); #1;
      end
    end
    bus_idle(2);
    for (int i = 0; i < 4; i++) check_val($sformatf("wait_seen_%0d", i), {31'b0, hist[i] > 0}, 32'd1);

    // Mixed random traffic with occasional bad addresses.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 60; n++) begin
        base = base_of(k);
        ix = $urandom_range(0, 255);
        a = base + 32'(ix) * 32'd4;
        case ($urandom_range(0, 9))
          0: a = a + 32'd1024;
          1: a = a + 32'($urandom_range(1, 3));
          2: a = base - 32'd4;
          default: a = a;
        endcase
        bus_txn(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0, 32'h0);
        if ($urandom_range(0, 2) == 0) begin
          bus_idle(k);
          @(posedge clk); #1;
        end
      end
      bus_idle(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
